// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S processor: decoded instruction codes, ALU op codes, control FSM states.
// Latency: none (types, constants and pure combinational helpers only).
// Backpressure: not applicable.
package k_and_s_pkg;

  // Instruction classes produced by the datapath decoder from the IR contents
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  // ALU operation select codes
  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  // Control FSM states
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_LOAD_1  = 4'd2,
    S_LOAD_2  = 4'd3,
    S_STORE_1 = 4'd4,
    S_STORE_2 = 4'd5,
    S_MOVE    = 4'd6,
    S_ALU     = 4'd7,
    S_BRANCH  = 4'd8,
    S_HALT    = 4'd9
  } ctrl_state_t;

  // ALU op for an arithmetic/logic instruction; OR for anything else (also the MOVE idiom)
  function automatic logic [1:0] alu_op_of(input decoded_instruction_type instr);
    logic [1:0] op;
    op = OP_OR;
    case (instr)
      I_ADD:   op = OP_ADD;
      I_SUB:   op = OP_SUB;
      I_AND:   op = OP_AND;
      default: op = OP_OR;
    endcase
    return op;
  endfunction

  // 1 for a branch-class instruction, 0 otherwise
  function automatic logic is_branch(input decoded_instruction_type instr);
    return (instr == I_BRANCH) || (instr == I_BZERO) || (instr == I_BNZERO) ||
           (instr == I_BNEG)   || (instr == I_BNNEG) || (instr == I_BOV)    ||
           (instr == I_BNOV);
  endfunction

  // Branch condition evaluated against the registered ALU flags
  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic zero_f,
                                        input logic neg_f,
                                        input logic uovf_f);
    logic taken;
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_f;
      I_BNZERO: taken = ~zero_f;
      I_BNEG:   taken = neg_f;
      I_BNNEG:  taken = ~neg_f;
      I_BOV:    taken = uovf_f;
      I_BNOV:   taken = ~uovf_f;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control FSM sequencing fetch/decode/execute for the K-and-S datapath.
// Latency: NOP/untaken branch 2 cycles, MOVE/ALU/taken branch 3, LOAD/STORE 4; HALT is terminal.
// Backpressure: none; the datapath is always ready, only reset leaves HALT.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  ctrl_state_t state_q, state_d;
  // ALU op is captured in DECODE so the ALU state drives it from a register
  logic [1:0]  alu_op_q, alu_op_d;

  // No branch condition tests signed overflow
  logic unused_signed_overflow;
  assign unused_signed_overflow = signed_overflow;

  // State register; reset lands in FETCH from any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      alu_op_q <= OP_OR;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

  // Next-state choice and per-state datapath controls
  always_comb begin
    state_d          = state_q;
    alu_op_d         = alu_op_q;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = OP_OR;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        state_d   = S_DECODE;
      end

      S_DECODE: begin
        alu_op_d = alu_op_of(decoded_instruction);
        case (decoded_instruction)
          I_LOAD:                     state_d = S_LOAD_1;
          I_STORE:                    state_d = S_STORE_1;
          I_MOVE:                     state_d = S_MOVE;
          I_ADD, I_SUB, I_AND, I_OR:  state_d = S_ALU;
          I_HALT:                     state_d = S_HALT;
          default: begin
            if (is_branch(decoded_instruction) &&
                branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow))
              state_d = S_BRANCH;
            else
              state_d = S_FETCH;
          end
        endcase
      end

      // Address phase; RAM read data arrives next cycle
      S_LOAD_1: begin
        addr_sel = 1'b1;
        state_d  = S_LOAD_2;
      end

      S_LOAD_2: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end

      S_STORE_1: begin
        addr_sel = 1'b1;
        state_d  = S_STORE_2;
      end

      S_STORE_2: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        state_d          = S_FETCH;
      end

      // Copy Ra through the ALU as Ra OR Ra, flags untouched
      S_MOVE: begin
        operation        = OP_OR;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end

      S_ALU: begin
        operation        = alu_op_q;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end

      S_BRANCH: begin
        pc_enable = 1'b1;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end

      S_HALT: begin
        halt    = 1'b1;
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Outputs are quiet while reset is held, so a STORE_2 hit by reset never writes RAM
    if (!rst_n) begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = OP_OR;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
    end
  end

endmodule
